// File: rtl/therm7_to_bin.sv
// 7-bit thermometer to binary converter with a two-stage valid/ready pipeline
// and a running accumulator of emitted counts with a sticky wrap flag.
module therm7_to_bin #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_count,
    output logic             out_err,
    input  logic             clr,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    logic             live;
    logic             s1_valid;
    logic [6:0]       s1_word;
    logic             s1_err;
    logic             s2_valid;
    logic [3:0]       s2_count;
    logic             s2_err;
    logic             s2_load;
    logic             s1_move;
    logic             in_fire;
    logic             out_fire;
    logic             word_bad;
    logic [3:0]       ones;
    logic [ACC_W:0]   sum;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_move   = s1_valid && s2_load;
    assign in_ready  = live && (!s1_valid || !s2_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign out_count = s2_count;
    assign out_err   = s2_err;

    always_comb begin
        word_bad = 1'b1;
        unique case (in_therm)
            7'b0000000, 7'b1000000, 7'b1100000, 7'b1110000,
            7'b1111000, 7'b1111100, 7'b1111110, 7'b1111111:
                word_bad = 1'b0;
            default:
                word_bad = 1'b1;
        endcase
    end

    // Popcount rather than priority decode, so bubbles still yield a count.
    always_comb begin
        ones = '0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + {3'b000, s1_word[i]};
        end
    end

    assign sum = {1'b0, acc} + (ACC_W + 1)'(s2_count);

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_err   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_word  <= in_therm;
            s1_err   <= word_bad;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_count <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_count <= ones;
                s2_err   <= s1_err;
            end
        end
    end

    // Clear wins over the old value but still counts a word leaving now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (clr) begin
            acc     <= out_fire ? ACC_W'(s2_count) : '0;
            acc_ovf <= 1'b0;
        end else if (out_fire) begin
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                acc_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_therm7_to_bin.sv
// Scoreboard bench for therm7_to_bin: a wide (16-bit) and a narrow (4-bit)
// accumulator instance share one stimulus stream.
module tb_therm7_to_bin;

    typedef struct {
        int cnt;
        int err;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_therm;
    logic        out_ready;
    logic        clr;

    logic        in_ready_a, out_valid_a, out_err_a, ovf_a;
    logic [3:0]  out_count_a;
    logic [15:0] acc_a;
    logic        in_ready_b, out_valid_b, out_err_b, ovf_b;
    logic [3:0]  out_count_b;
    logic [3:0]  acc_b;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          armed = 0;
    bit          lat_chk = 0;
    int unsigned m_acc16 = 0;
    int unsigned m_acc4 = 0;
    bit          m_ovf16 = 0;
    bit          m_ovf4 = 0;
    bit          prev_stall = 0;
    int          prev_cnt = 0;
    int          prev_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    therm7_to_bin #(.ACC_W(16)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_therm(in_therm),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_count(out_count_a), .out_err(out_err_a),
        .clr(clr), .acc(acc_a), .acc_ovf(ovf_a)
    );

    therm7_to_bin #(.ACC_W(4)) u_narrow (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_therm(in_therm),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_count(out_count_b), .out_err(out_err_b),
        .clr(clr), .acc(acc_b), .acc_ovf(ovf_b)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int n_ones(input logic [6:0] w);
        int n = 0;
        for (int i = 0; i < 7; i++) if (w[i]) n++;
        return n;
    endfunction

    function automatic logic [6:0] legal_pat(input int m);
        return 7'((127 << (7 - m)) & 127);
    endfunction

    function automatic int is_legal(input logic [6:0] w);
        for (int m = 0; m <= 7; m++) if (w == legal_pat(m)) return 1;
        return 0;
    endfunction

    // Record each accepted word; runs after the monitor in the same half cycle.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (in_valid && in_ready_a) begin
            e.cnt = n_ones(in_therm);
            e.err = is_legal(in_therm) ? 0 : 1;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int c;
        bit outf;
        int unsigned s;
        check("acc_wide", int'(acc_a), int'(m_acc16));
        check("acc_narrow", int'(acc_b), int'(m_acc4));
        check("ovf_wide", int'(ovf_a), int'(m_ovf16));
        check("ovf_narrow", int'(ovf_b), int'(m_ovf4));
        check("in_ready_wide", int'(in_ready_a),
              int'(armed && (q.size() < 2 || out_ready)));
        check("in_ready_narrow", int'(in_ready_b),
              int'(armed && (q.size() < 2 || out_ready)));
        if (prev_stall) begin
            check("hold_valid", int'(out_valid_a), 1);
            check("hold_count", int'(out_count_a), prev_cnt);
            check("hold_err", int'(out_err_a), prev_err);
        end
        prev_stall = out_valid_a && !out_ready;
        prev_cnt = int'(out_count_a);
        prev_err = int'(out_err_a);
        outf = out_valid_a && out_ready;
        c = 0;
        if (outf) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                c = e.cnt;
                check("count_wide", int'(out_count_a), e.cnt);
                check("err_wide", int'(out_err_a), e.err);
                check("count_narrow", int'(out_count_b), e.cnt);
                check("err_narrow", int'(out_err_b), e.err);
                if (lat_chk) check("latency", cyc + 1 - e.cyc, 2);
            end
        end
        if (clr) begin
            m_acc16 = outf ? c : 0;
            m_acc4 = outf ? c : 0;
            m_ovf16 = 0;
            m_ovf4 = 0;
        end else if (outf) begin
            s = m_acc16 + c;
            if (s >= 65536) m_ovf16 = 1;
            m_acc16 = s % 65536;
            s = m_acc4 + c;
            if (s >= 16) m_ovf4 = 1;
            m_acc4 = s % 16;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] w);
        bit took;
        int n = 0;
        in_valid = 1'b1;
        in_therm = w;
        do begin
            took = in_ready_a;
            step();
            n++;
        end while (!took && n < 200);
        if (!took) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        step();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        armed = 0;
        q.delete();
        m_acc16 = 0;
        m_acc4 = 0;
        m_ovf16 = 0;
        m_ovf4 = 0;
        prev_stall = 0;
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_count", int'(out_count_a), 0);
        check("rst_out_err", int'(out_err_a), 0);
        check("rst_acc", int'(acc_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_in_ready", int'(in_ready_a), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        armed = 1;
    endtask

    initial begin
        int idx;
        bit took;
        bit hit;
        logic [6:0] bp[5];
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_therm = '0;
        out_ready = 1'b1;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        armed = 1;

        lat_chk = 1;
        for (int m = 0; m <= 7; m++) send(legal_pat(m));
        drain();
        check("sweep_acc", int'(acc_a), 28);

        pulse_clr();
        send(7'b0101000);
        send(7'b0000001);
        drain();
        check("bubble_acc", int'(acc_a), 3);
        lat_chk = 0;

        bp[0] = 7'b1000000;
        bp[1] = 7'b1110000;
        bp[2] = 7'b0011000;
        bp[3] = 7'b1111110;
        bp[4] = 7'b1100000;
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_therm = bp[idx];
            took = in_ready_a;
            step();
            if (took) idx++;
        end
        check("stall_accepts", idx, 2);
        out_ready = 1'b1;
        while (idx < 5) begin
            send(bp[idx]);
            idx++;
        end
        drain();

        pulse_clr();
        repeat (3) send(7'b1111111);
        drain();
        check("ovf_acc_narrow", int'(acc_b), 5);
        check("ovf_flag_narrow", int'(ovf_b), 1);
        check("ovf_acc_wide", int'(acc_a), 21);

        pulse_clr();
        send(7'b1111111);
        send(7'b1100000);
        drain();
        check("pre_clr_acc", int'(acc_a), 9);
        send(7'b1110000);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (out_valid_a && out_count_a == 4'd3) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                hit = 1;
            end else begin
                step();
            end
        end
        check("clr_hit", int'(hit), 1);
        check("clr_collide_acc", int'(acc_a), 3);
        check("clr_collide_ovf", int'(ovf_a), 0);

        out_ready = 1'b0;
        send(7'b1111000);
        send(7'b1111100);
        in_valid = 1'b1;
        in_therm = 7'b1111111;
        async_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("no_stale", int'(out_valid_a), 0);
            step();
        end

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_therm = ($urandom % 2) ? legal_pat($urandom_range(0, 7))
                                      : 7'($urandom);
            out_ready = ($urandom % 4) != 0;
            clr = ($urandom % 20) == 0;
            step();
        end
        clr = 1'b0;
        drain();
        check("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
